// File: rtl/icm_lookup_engine_pkg.sv
// Shared constants, opcode encodings and table-entry layout for the ICM lookup engine.
package icm_lookup_engine_pkg;

  localparam int unsigned ICM_PAGE_SHIFT       = 12;
  localparam int unsigned ICM_SPACE_ADDR_WIDTH = 64;
  localparam int unsigned PHY_SPACE_ADDR_WIDTH = 64;
  localparam int unsigned ICM_ENTRY_NUM_MPT    = 1024;

  localparam logic ICM_OP_MAP   = 1'b1;
  localparam logic ICM_OP_UNMAP = 1'b0;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } icm_state_e;

  typedef struct packed {
    logic                                           valid;
    logic [PHY_SPACE_ADDR_WIDTH-ICM_PAGE_SHIFT-1:0] phy_page;
  } icm_entry_t;

endpackage

// File: rtl/icm_map_table_sdp.sv
// Generic simple dual-port RAM: one write port, one read port, read-first, 1-cycle read latency.
module icm_map_table_sdp #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 53,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/icm_lookup_engine.sv
// ICM page -> physical page lookup engine: table clear FSM, map/unmap port, 2-cycle lookup pipeline.
module icm_lookup_engine #(
  parameter int ICM_ENTRY_NUM        = icm_lookup_engine_pkg::ICM_ENTRY_NUM_MPT,
  parameter int ICM_ENTRY_NUM_LOG    = 10,
  parameter int ICM_SPACE_ADDR_WIDTH = icm_lookup_engine_pkg::ICM_SPACE_ADDR_WIDTH,
  parameter int PHY_SPACE_ADDR_WIDTH = icm_lookup_engine_pkg::PHY_SPACE_ADDR_WIDTH,
  parameter int ICM_PAGE_SHIFT       = icm_lookup_engine_pkg::ICM_PAGE_SHIFT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            lookup_valid,
  input  logic [ICM_ENTRY_NUM_LOG-1:0]    lookup_head,
  output logic                            rsp_valid,
  output logic [ICM_SPACE_ADDR_WIDTH-1:0] rsp_icm_addr,
  output logic [PHY_SPACE_ADDR_WIDTH-1:0] rsp_phy_addr,
  output logic                            rsp_hit,
  input  logic                            map_valid,
  output logic                            map_ready,
  input  logic                            map_opcode,
  input  logic [ICM_ENTRY_NUM_LOG-1:0]    map_head,
  input  logic [PHY_SPACE_ADDR_WIDTH-1:0] map_phy_addr,
  output logic                            init_done
);

  import icm_lookup_engine_pkg::*;

  localparam int PAGE_W  = PHY_SPACE_ADDR_WIDTH - ICM_PAGE_SHIFT;
  localparam int ENTRY_W = PAGE_W + 1;
  localparam int CNT_W   = ICM_ENTRY_NUM_LOG + 1;

  icm_state_e                   state_q, state_d;
  logic [CNT_W-1:0]             init_cnt_q, init_cnt_d;

  logic                         tbl_we;
  logic [ICM_ENTRY_NUM_LOG-1:0] tbl_waddr;
  logic [ENTRY_W-1:0]           tbl_wdata;
  logic [ENTRY_W-1:0]           tbl_rdata;

  logic                         s1_valid_q, s1_byp_q, s1_init_q;
  logic [ICM_ENTRY_NUM_LOG-1:0] s1_head_q;
  logic [ENTRY_W-1:0]           s1_byp_data_q;

  logic                         byp_hit;
  logic [ENTRY_W-1:0]           s2_entry;
  logic                         rsp_hit_d;
  logic [ICM_SPACE_ADDR_WIDTH-1:0] rsp_icm_d;
  logic [PHY_SPACE_ADDR_WIDTH-1:0] rsp_phy_d;

  logic [ICM_PAGE_SHIFT-1:0]    unused_phy_lsb;
  assign unused_phy_lsb = map_phy_addr[ICM_PAGE_SHIFT-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    tbl_we     = 1'b0;
    tbl_waddr  = map_head;
    tbl_wdata  = '0;
    map_ready  = 1'b0;
    init_done  = 1'b0;
    case (state_q)
      ST_INIT: begin
        tbl_we     = 1'b1;
        tbl_waddr  = init_cnt_q[ICM_ENTRY_NUM_LOG-1:0];
        init_cnt_d = init_cnt_q + CNT_W'(1);
        if (init_cnt_q == CNT_W'(ICM_ENTRY_NUM - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        map_ready = 1'b1;
        init_done = 1'b1;
        tbl_we    = map_valid;
        if (map_opcode == ICM_OP_MAP) begin
          tbl_wdata = {1'b1, map_phy_addr[PHY_SPACE_ADDR_WIDTH-1:ICM_PAGE_SHIFT]};
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  icm_map_table_sdp #(
    .DEPTH  (ICM_ENTRY_NUM),
    .WIDTH  (ENTRY_W),
    .ADDR_W (ICM_ENTRY_NUM_LOG)
  ) u_table (
    .clk_i   (clk),
    .we_i    (tbl_we),
    .waddr_i (tbl_waddr),
    .wdata_i (tbl_wdata),
    .raddr_i (lookup_head),
    .rdata_o (tbl_rdata)
  );

  // The RAM is read-first, so a same-cycle update to the looked-up head is forwarded here.
  assign byp_hit = map_ready && map_valid && (map_head == lookup_head);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_byp_q      <= 1'b0;
      s1_init_q     <= 1'b0;
      s1_head_q     <= '0;
      s1_byp_data_q <= '0;
    end else begin
      s1_valid_q    <= lookup_valid;
      s1_byp_q      <= byp_hit;
      s1_init_q     <= (state_q == ST_INIT);
      s1_head_q     <= lookup_head;
      s1_byp_data_q <= tbl_wdata;
    end
  end

  always_comb begin
    s2_entry  = s1_byp_q ? s1_byp_data_q : tbl_rdata;
    rsp_hit_d = s2_entry[PAGE_W] & ~s1_init_q;
    rsp_phy_d = '0;
    if (rsp_hit_d) begin
      rsp_phy_d = {s2_entry[PAGE_W-1:0], {ICM_PAGE_SHIFT{1'b0}}};
    end
    rsp_icm_d = ICM_SPACE_ADDR_WIDTH'(s1_head_q) << ICM_PAGE_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_hit      <= 1'b0;
      rsp_icm_addr <= '0;
      rsp_phy_addr <= '0;
    end else begin
      rsp_valid    <= s1_valid_q;
      rsp_hit      <= rsp_hit_d;
      rsp_icm_addr <= rsp_icm_d;
      rsp_phy_addr <= rsp_phy_d;
    end
  end

endmodule

// File: tb/tb_icm_lookup_engine.sv
// Scoreboard bench for icm_lookup_engine: directed lookups/maps, expected responses queued at issue time.
module tb_icm_lookup_engine;

  logic        clk;
  logic        rst;
  logic        lookup_valid;
  logic [9:0]  lookup_head;
  logic        rsp_valid;
  logic [63:0] rsp_icm_addr;
  logic [63:0] rsp_phy_addr;
  logic        rsp_hit;
  logic        map_valid;
  logic        map_ready;
  logic        map_opcode;
  logic [9:0]  map_head;
  logic [63:0] map_phy_addr;
  logic        init_done;

  typedef struct {
    int unsigned cyc;
    logic        hit;
    logic [63:0] icm;
    logic [63:0] phy;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  icm_lookup_engine #(
    .ICM_ENTRY_NUM        (1024),
    .ICM_ENTRY_NUM_LOG    (10),
    .ICM_SPACE_ADDR_WIDTH (64),
    .PHY_SPACE_ADDR_WIDTH (64),
    .ICM_PAGE_SHIFT       (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_head  (lookup_head),
    .rsp_valid    (rsp_valid),
    .rsp_icm_addr (rsp_icm_addr),
    .rsp_phy_addr (rsp_phy_addr),
    .rsp_hit      (rsp_hit),
    .map_valid    (map_valid),
    .map_ready    (map_ready),
    .map_opcode   (map_opcode),
    .map_head     (map_head),
    .map_phy_addr (map_phy_addr),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented response must match the oldest queued expectation, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected no response", cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
        chk("rsp_icm_addr", rsp_icm_addr, e.icm);
        chk("rsp_phy_addr", rsp_phy_addr, e.phy);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    lookup_valid = 1'b0;
    map_valid    = 1'b0;
  endtask

  task automatic lk(input logic [9:0] head, input logic hit, input logic [63:0] phy);
    exp_t e;
    lookup_valid = 1'b1;
    lookup_head  = head;
    e.cyc = cyc + 2;
    e.hit = hit;
    e.icm = 64'(head) << 12;
    e.phy = phy;
    sb.push_back(e);
  endtask

  task automatic map_cmd(input logic op, input logic [9:0] head, input logic [63:0] addr);
    map_valid    = 1'b1;
    map_opcode   = op;
    map_head     = head;
    map_phy_addr = addr;
  endtask

  task automatic wait_init(input bit probe);
    int found;
    found = 0;
    for (int k = 1; k <= 1100; k++) begin
      if (probe && k == 10) lk(10'd5, 1'b0, 64'h0);
      else lookup_valid = 1'b0;
      step();
      if (k == 1) begin
        chk("init_done_early", 64'(init_done), 64'h0);
        chk("map_ready_early", 64'(map_ready), 64'h0);
        chk("rsp_valid_after_rst", 64'(rsp_valid), 64'h0);
      end
      if (init_done === 1'b1) begin
        found = k;
        break;
      end
    end
    chk("init_cycles", 64'(found), 64'd1024);
    chk("map_ready_run", 64'(map_ready), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    lookup_valid = 1'b0;
    lookup_head  = '0;
    map_valid    = 1'b0;
    map_opcode   = 1'b0;
    map_head     = '0;
    map_phy_addr = '0;
    repeat (2) step();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_hit", 64'(rsp_hit), 64'h0);
    chk("rst_rsp_icm", rsp_icm_addr, 64'h0);
    chk("rst_rsp_phy", rsp_phy_addr, 64'h0);
    chk("rst_map_ready", 64'(map_ready), 64'h0);
    chk("rst_init_done", 64'(init_done), 64'h0);
    rst = 1'b0;
    wait_init(1'b1);

    // Map then look up
    map_cmd(1'b1, 10'd3, 64'h0000_0008_0000_1ABC); step(); idle();
    lk(10'd3, 1'b1, 64'h0000_0008_0000_1000); step(); idle();

    // Same-cycle bypass, and an update one cycle after the lookup is not seen
    lk(10'd7, 1'b0, 64'h0); step(); idle();
    map_cmd(1'b1, 10'd7, 64'h2000); lk(10'd7, 1'b1, 64'h2000); step(); idle();
    lk(10'd7, 1'b1, 64'h2000); step(); idle();
    map_cmd(1'b1, 10'd7, 64'h4000); step(); idle();
    lk(10'd7, 1'b1, 64'h4000); step(); idle();

    // Unmap
    map_cmd(1'b0, 10'd3, 64'h0); step(); idle();
    lk(10'd3, 1'b0, 64'h0); step(); idle();

    // Streaming lookups; head 7 still holds 0x4000, heads 3 and 5 are unmapped
    for (int h = 0; h < 16; h += 2) begin
      map_cmd(1'b1, 10'(h), 64'(h) * 64'h10000); step();
    end
    idle();
    for (int h = 0; h < 16; h++) begin
      if (h % 2 == 0) lk(10'(h), 1'b1, 64'(h) * 64'h10000);
      else if (h == 7) lk(10'(h), 1'b1, 64'h4000);
      else lk(10'(h), 1'b0, 64'h0);
      step();
    end
    idle();
    repeat (4) step();
    chk("sb_drained", 64'(sb.size()), 64'h0);

    // Reset with two lookups in flight: neither may produce a response
    lookup_valid = 1'b1; lookup_head = 10'd1; step();
    lookup_head = 10'd2; rst = 1'b1; step();
    lookup_valid = 1'b0;
    chk("rsp_dropped", 64'(rsp_valid), 64'h0);
    step();
    chk("rsp_dropped_2", 64'(rsp_valid), 64'h0);
    rst = 1'b0;
    wait_init(1'b0);
    lk(10'd7, 1'b0, 64'h0); step(); idle();
    repeat (4) step();
    chk("sb_drained_final", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
